// File: rtl/mem_pkg.sv
// Shared definitions for the main-memory responder: bus widths and FSM state encoding.
package mem_pkg;

  localparam int MEM_ADR_W  = 27;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port 2^AW x 32 word array with per-byte write enables and a registered read port.
module mem_responder_ram
  import mem_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic                  ph1,
  input  logic                  reset,
  input  logic [AW-1:0]         adr,
  input  logic [MEM_DATA_W-1:0] wdata,
  input  logic [3:0]            byteen,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [MEM_DATA_W-1:0] rdata
);

  logic [MEM_DATA_W-1:0] mem_r [0:(1<<AW)-1];
  logic [MEM_DATA_W-1:0] rdata_r;

  // Byte-lane writes; the array itself is never reset so it maps onto block RAM.
  always_ff @(posedge ph1) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en && byteen[i]) begin
        mem_r[adr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read register holds the last read word until the next read or a reset clears it.
  always_ff @(posedge ph1) begin
    if (reset) begin
      rdata_r <= {MEM_DATA_W{1'b0}};
    end else if (rd_en) begin
      rdata_r <= mem_r[adr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/mem_responder.sv
// Memory-side endpoint of the cache controller's main-memory port: captures a request,
// waits WAIT cycles, then commits a byte-enabled write or returns a read word with memdone.
module mem_responder
  import mem_pkg::*;
#(
  parameter int AW   = 12,
  parameter int WAIT = 1
) (
  input  logic                  ph1,
  input  logic                  reset,
  input  logic [MEM_ADR_W-1:0]  memadr,
  input  logic [MEM_DATA_W-1:0] memwdata,
  input  logic [3:0]            membyteen,
  input  logic                  memrwb,
  input  logic                  memen,
  output logic                  memdone,
  output logic [MEM_DATA_W-1:0] memrdata,
  output logic                  busy
);

  if (WAIT < 0 || WAIT > 15) begin : g_wait_check
    $error("mem_responder: WAIT must be in 0..15");
  end

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  state_t                state_r;
  state_t                state_nxt_s;
  logic [3:0]            cnt_r;
  logic [AW-1:0]         adr_r;
  logic [MEM_DATA_W-1:0] wdata_r;
  logic [3:0]            byteen_r;
  logic                  rwb_r;
  logic                  memdone_r;
  logic                  busy_r;

  logic [AW-1:0]         req_adr_s;
  logic [MEM_DATA_W-1:0] req_wdata_s;
  logic [3:0]            req_byteen_s;
  logic                  req_rwb_s;
  logic                  enter_done_s;
  logic                  wr_en_s;
  logic                  rd_en_s;
  logic                  unused_adr_s;

  assign unused_adr_s = ^memadr[MEM_ADR_W-1:AW];

  // State, wait counter and registered status outputs.
  always_ff @(posedge ph1) begin
    if (reset) begin
      state_r   <= S_IDLE;
      cnt_r     <= 4'd0;
      memdone_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      memdone_r <= (state_nxt_s == S_DONE);
      busy_r    <= (state_nxt_s != S_IDLE);
      if (state_r == S_IDLE && memen) begin
        cnt_r <= WAIT_CNT;
      end else if (state_r == S_BUSY && memen && cnt_r > 4'd1) begin
        cnt_r <= cnt_r - 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Request capture; later changes on the bus must not leak into an accepted request.
  always_ff @(posedge ph1) begin
    if (reset) begin
      adr_r    <= {AW{1'b0}};
      wdata_r  <= {MEM_DATA_W{1'b0}};
      byteen_r <= 4'b0000;
      rwb_r    <= 1'b0;
    end else if (state_r == S_IDLE && memen) begin
      adr_r    <= memadr[AW-1:0];
      wdata_r  <= memwdata;
      byteen_r <= membyteen;
      rwb_r    <= memrwb;
    end else begin
      adr_r    <= adr_r;
      wdata_r  <= wdata_r;
      byteen_r <= byteen_r;
      rwb_r    <= rwb_r;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (memen) begin
          state_nxt_s = (WAIT_CNT == 4'd0) ? S_DONE : S_BUSY;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_BUSY: begin
        if (!memen) begin
          state_nxt_s = S_IDLE;
        end else if (cnt_r <= 4'd1) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_BUSY;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Array strobes fire on the edge that enters DONE; with WAIT=0 that is the capture edge,
  // so the live bus is used while still in IDLE.
  always_comb begin
    req_adr_s    = adr_r;
    req_wdata_s  = wdata_r;
    req_byteen_s = byteen_r;
    req_rwb_s    = rwb_r;
    if (state_r == S_IDLE) begin
      req_adr_s    = memadr[AW-1:0];
      req_wdata_s  = memwdata;
      req_byteen_s = membyteen;
      req_rwb_s    = memrwb;
    end else begin
      req_adr_s    = adr_r;
      req_wdata_s  = wdata_r;
      req_byteen_s = byteen_r;
      req_rwb_s    = rwb_r;
    end
    enter_done_s = (state_nxt_s == S_DONE) && (state_r != S_DONE) && !reset;
    wr_en_s      = enter_done_s && !req_rwb_s;
    rd_en_s      = enter_done_s && req_rwb_s;
  end

  mem_responder_ram #(
    .AW(AW)
  ) u_ram (
    .ph1   (ph1),
    .reset (reset),
    .adr   (req_adr_s),
    .wdata (req_wdata_s),
    .byteen(req_byteen_s),
    .wr_en (wr_en_s),
    .rd_en (rd_en_s),
    .rdata (memrdata)
  );

  assign memdone = memdone_r;
  assign busy    = busy_r;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Synthesizable memory-side endpoint of the main-memory port driven by cachecontroller.
- Accepts a request held on memadr/membyteen/memrwb/memen, waits a programmable number of cycles, then commits a byte-enabled write or returns a read word, and pulses memdone for one cycle.
- Replaces the behavioural main memory in synthesis builds and FPGA bring-up.
- The bidirectional memdata bus is split into memwdata and memrdata; the top level ties them to the shared bus.

Parameters:
- AW, 12: word-address bits used to index the array (depth 2^AW words). Upper memadr bits [26:AW] are ignored, so addresses alias.
- WAIT, 1: wait cycles between request capture and completion, 0..15.

Ports:
- ph1  in  1  sole clock, rising-edge active; no ph2 input.
- reset  in  1  synchronous, active-high.
- memadr  in  27  word address.
- memwdata  in  32  write data.
- membyteen  in  4  byte enables for writes (bit i = byte [8i+7:8i]); ignored on reads.
- memrwb  in  1  1 = read, 0 = write.
- memen  in  1  request valid; held with stable adr/data/byteen/rwb until memdone.
- memdone  out  1  one-cycle completion pulse.
- memrdata  out  32  read data; valid while memdone=1 for a read, then held.
- busy  out  1  a request is captured and not yet completed.

Behaviour:
- Reset: one clock and reset; reset is synchronous and active-high.
  - Outputs after reset: state=IDLE, memdone=0, memrdata=0, busy=0, wait counter=0.
  - Array contents are not cleared.
  - Reset asserted mid-request aborts the request: no array write, no memdone.
- State machine (state register updated on the ph1 rising edge):
  - IDLE: if memen=1, capture adr[AW-1:0], rwb, byteen and wdata into request registers, load cnt=WAIT, and go to BUSY (or DONE directly when WAIT=0). Otherwise stay in IDLE.
  - BUSY: if memen=0, abort and go to IDLE with no write and no memdone. Else if cnt==1 or cnt==0, go to DONE. Else decrement cnt.
  - DONE: memdone=1 for exactly this cycle, then go to IDLE unconditionally.
- Commit and read timing:
  - Writes commit on the clock edge that enters DONE.
  - Reads load memrdata from the array on that same edge, so memrdata is valid in the same cycle memdone is high.
- Latency: memdone rises WAIT+1 cycles after the first edge sampling memen=1. With WAIT=1 the sequence is IDLE → BUSY → DONE, giving 2 cycles.
- Writes: only bytes with membyteen[i]=1 are updated. byteen=0000 still completes with memdone but modifies nothing.
- Reads: return the full 32-bit word regardless of byteen. memrdata holds its value until the next read completes; writes do not disturb it.
- Captured values are used, not live inputs. Changes to memadr, memwdata or membyteen after capture do not affect the request.
- Back-to-back requests:
  - The cycle after DONE is IDLE.
  - If memen is still 1 there, it is treated as a new request (same handshake as cachecontroller, which drops memen for at least one cycle).
  - Minimum request spacing is WAIT+2 cycles.
- Read-after-write to the same address in consecutive requests returns the new data; the array is written before the next capture.
- busy = (state != IDLE).
- Invalid WAIT values (above 15) are a configuration error and are checked at elaboration.

Decomposition:
- Shared package mem_pkg:
  - State encodings: S_IDLE=2'b00, S_BUSY=2'b01, S_DONE=2'b10.
  - Constant MEM_ADR_W=27.
  - Constant MEM_DATA_W=32.
- Sub-module mem_responder_ram:
  - Single-port synchronous array of 2^AW x 32.
  - Per-byte write enables and a registered read port, clocked by ph1.
  - Maps to FPGA block RAM.

Test Plan:
- Basic write then read (WAIT=1):
  - Stimulus: write adr=0x0AD, data=0xBEADBEEF, byteen=1111, then read adr=0x0AD.
  - Required response: memdone 2 cycles after each memen, and memrdata=0xBEADBEEF during the read memdone.
- Partial write:
  - Stimulus: write 0x11223344 to adr=5, then write 0xAABBCCDD with byteen=0101, then read adr=5.
  - Required response: memrdata=0x11BB33DD.
- Abort:
  - Stimulus: with WAIT=3, issue write 0xFFFFFFFF to adr=7, then drop memen in the second BUSY cycle.
  - Required response: no memdone, and a following read of adr=7 returns the prior value 0x00000000.
- Reset mid-request:
  - Stimulus: assert reset while in BUSY.
  - Required response: next cycle memdone=0, busy=0, memrdata=0, and array location unchanged.
- Aliasing and WAIT=0:
  - Stimulus: with AW=12, write 0x21212121 to adr=0x0004AD, then read adr=0x0014AD.
  - Required response: memrdata=0x21212121, with memdone 1 cycle after memen.
- Back-to-back:
  - Stimulus: hold memen=1 across two reads of adr=0 and adr=1.
  - Required response: memdone pulses are separated by exactly WAIT+2 cycles, and each pulse is 1 cycle wide.
